// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// aes_key_expand : AES-128/256 key schedule, one round key per cycle, stored
//                  in a 15-entry table with a shared external S-box.
// Revision 1.0
// ============================================================================
module aes_key_expand #(
  parameter logic       AES_128_BIT_KEY = 1'h0,
  parameter logic       AES_256_BIT_KEY = 1'h1,
  parameter logic [3:0] AES128_ROUNDS   = 4'ha,
  parameter logic [3:0] AES256_ROUNDS   = 4'he
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_GEN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]   r_state;
  logic [1:0]   w_state_next;
  logic [3:0]   r_round_ctr;
  logic [7:0]   r_rcon;
  logic [127:0] r_prev_key0;
  logic [127:0] r_prev_key1;
  logic [127:0] r_key_mem [15];
  logic         r_ready;

  logic         w_ready_we;
  logic         w_ready_new;
  logic         w_ctr_rst;
  logic         w_ctr_inc;
  logic         w_rcon_init;
  logic         w_key_we;
  logic         w_rcon_upd;
  logic [127:0] w_new_key;
  logic [3:0]   w_num_rounds;
  logic         w_is_128;
  logic [31:0]  w_trw;

  function automatic logic [127:0] chain(input logic [127:0] p, input logic [31:0] t);
    logic [31:0] w0, w1, w2, w3;
    w0 = p[127:96] ^ t;
    w1 = p[95:64]  ^ w0;
    w2 = p[63:32]  ^ w1;
    w3 = p[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  assign w_is_128     = (keylen == AES_128_BIT_KEY);
  assign w_num_rounds = (keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
  assign sboxw        = r_prev_key1[31:0];
  assign ready        = r_ready;
  // S-box is byte-wise, so rotating after substitution equals SubWord(RotWord()).
  assign w_trw        = {new_sboxw[23:0], new_sboxw[31:24]} ^ {r_rcon, 24'h0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (init) w_state_next = S_INIT;
      S_INIT:  w_state_next = S_GEN;
      S_GEN:   if (r_round_ctr == w_num_rounds) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready_we  = 1'b0;
    w_ready_new = 1'b0;
    w_ctr_rst   = 1'b0;
    w_ctr_inc   = 1'b0;
    w_rcon_init = 1'b0;
    w_key_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (init) begin
          w_ready_we = 1'b1;
          w_ctr_rst  = 1'b1;
        end
      end
      S_INIT: w_rcon_init = 1'b1;
      S_GEN: begin
        w_key_we  = 1'b1;
        w_ctr_inc = 1'b1;
      end
      S_DONE: begin
        w_ready_we  = 1'b1;
        w_ready_new = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_new_key  = key[255:128];
    w_rcon_upd = 1'b0;
    if (r_round_ctr != 4'd0) begin
      if (w_is_128) begin
        w_new_key  = chain(r_prev_key1, w_trw);
        w_rcon_upd = 1'b1;
      end else if (r_round_ctr == 4'd1) begin
        w_new_key = key[127:0];
      end else if (!r_round_ctr[0]) begin
        w_new_key  = chain(r_prev_key0, w_trw);
        w_rcon_upd = 1'b1;
      end else begin
        w_new_key = chain(r_prev_key0, new_sboxw);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready     <= 1'b1;
      r_round_ctr <= 4'd0;
      r_rcon      <= 8'h01;
      r_prev_key0 <= '0;
      r_prev_key1 <= '0;
    end else begin
      if (w_ready_we) r_ready <= w_ready_new;
      if (w_ctr_rst)      r_round_ctr <= 4'd0;
      else if (w_ctr_inc) r_round_ctr <= r_round_ctr + 4'd1;
      if (w_rcon_init)                 r_rcon <= 8'h01;
      else if (w_key_we && w_rcon_upd) r_rcon <= gm2(r_rcon);
      if (w_key_we) begin
        r_prev_key0 <= r_prev_key1;
        r_prev_key1 <= w_new_key;
      end
    end
  end

  for (genvar g = 0; g < 15; g++) begin : g_key_mem
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        r_key_mem[g] <= '0;
      else if (w_key_we && (r_round_ctr == 4'(g)))
        r_key_mem[g] <= w_new_key;
    end
  end

  always_comb begin
    round_key = '0;
    if (round <= 4'd14) round_key = r_key_mem[round];
  end

endmodule
`default_nettype wire
